// File: rtl/seq_ctrl.sv
// Stage sequencer for the Y86-64 SEQ datapath: one-hot stage enables, CC/condition state, data memory handshake and status.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module seq_ctrl #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] icode,
  input  logic       instr_valid,
  input  logic       imem_error,
  input  logic [2:0] cc_in,
  input  logic       cnd_in,
  input  logic       mem_ack,
  input  logic       dmem_error,
  output logic       f_en,
  output logic       d_en,
  output logic       e_en,
  output logic       m_en,
  output logic       w_en,
  output logic       pc_en,
  output logic       mem_req,
  output logic       set_cc,
  output logic [2:0] cc_out,
  output logic       cnd_q,
  output logic [2:0] stat,
  output logic       busy
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ins_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PC, S_HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // The wait counter only needs to reach MEM_WAIT_MAX-1, the last cycle allowed without an ack.
  localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam int WAIT_LAST_I = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
  localparam logic [WW-1:0] WAIT_LAST = WAIT_LAST_I[WW-1:0];

  state_t        state_q, state_d;
  logic [2:0]    stat_q, stat_d;
  logic [2:0]    cc_q, cc_d;
  logic          cnd_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          is_mem_op;

  assign is_mem_op = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                     (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      cc_q    <= 3'b100;
      cnd_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      cc_q    <= cc_d;
      cnd_q   <= cnd_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    cc_d    = cc_q;
    cnd_d   = cnd_q;
    wait_d  = wait_q;
    f_en    = 1'b0;
    d_en    = 1'b0;
    e_en    = 1'b0;
    m_en    = 1'b0;
    w_en    = 1'b0;
    pc_en   = 1'b0;
    mem_req = 1'b0;
    set_cc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        f_en = 1'b1;
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALTED;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        d_en    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        e_en    = 1'b1;
        wait_d  = '0;
        state_d = S_MEM;
        if (icode == 4'h6) begin
          set_cc = 1'b1;
          cc_d   = cc_in;
        end
        if ((icode == 4'h2) || (icode == 4'h7)) cnd_d = cnd_in;
      end
      S_MEM: begin
        m_en = 1'b1;
        if (!is_mem_op) begin
          state_d = S_WB;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            if (dmem_error) begin
              stat_d  = STAT_ADR;
              state_d = S_HALTED;
            end else begin
              state_d = S_WB;
            end
          end else if ((MEM_WAIT_MAX != 0) && (wait_q == WAIT_LAST)) begin
            stat_d  = STAT_ADR;
            state_d = S_HALTED;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
      end
      S_WB: begin
        w_en    = 1'b1;
        state_d = S_PC;
      end
      S_PC: begin
        if (icode == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALTED;
        end else begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  assign cc_out = cc_q;
  assign stat   = stat_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_HALTED);

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (busy)  cyc_q <= cyc_q + CNT_W'(1);
      if (pc_en) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl; inputs change and outputs are sampled on the falling clock edge.
// Performance counter checks are compiled in when SEQ_PERF_CNT_EN is defined.
module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, instr_valid, imem_error, cnd_in, mem_ack, dmem_error;
  logic [3:0] icode;
  logic [2:0] cc_in;
  logic       f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, set_cc, cnd_q, busy;
  logic [2:0] cc_out, stat;
  logic [5:0] ens;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt, ins_cnt;
`endif

  int numChecks = 0;
  int numFails  = 0;

  assign ens = {f_en, d_en, e_en, m_en, w_en, pc_en};

  always #5 clk = ~clk;

  seq_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .cc_in(cc_in), .cnd_in(cnd_in), .mem_ack(mem_ack),
    .dmem_error(dmem_error), .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en),
    .w_en(w_en), .pc_en(pc_en), .mem_req(mem_req), .set_cc(set_cc), .cc_out(cc_out),
    .cnd_q(cnd_q), .stat(stat), .busy(busy)
`ifdef SEQ_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
`endif
  );

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
    cc_in = 3'b000; cnd_in = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs FETCH..EXEC of icode ic, then the MEM stage; raises ack on MEM cycle ackAt (0 = never).
  task automatic mem_phase(input logic [3:0] ic, input int ackAt, input logic err,
                           output int nm, output int nr);
    @(negedge clk); start = 1'b0; icode = ic;
    repeat (2) @(negedge clk);
    nm = 0; nr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!m_en) break;
      nm++;
      if (mem_req) nr++;
      mem_ack = (nm == ackAt); dmem_error = (nm == ackAt) ? err : 1'b0;
    end
    mem_ack = 1'b0; dmem_error = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    numChecks++; if (ens !== 6'b0) begin numFails++; $display("[TB] FAIL reset_ens got %b want 000000", ens); end
    numChecks++; if (mem_req !== 1'b0 || set_cc !== 1'b0) begin numFails++; $display("[TB] FAIL reset_req_cc got req=%b set_cc=%b want 0 0", mem_req, set_cc); end
    numChecks++; if (cc_out !== 3'b100) begin numFails++; $display("[TB] FAIL reset_cc_out got %b want 100", cc_out); end
    numChecks++; if (cnd_q !== 1'b0) begin numFails++; $display("[TB] FAIL reset_cnd got %b want 0", cnd_q); end
    numChecks++; if (stat !== 3'd1) begin numFails++; $display("[TB] FAIL reset_stat got %0d want 1", stat); end
    numChecks++; if (busy !== 1'b0) begin numFails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    numChecks++; if (busy !== 1'b0 || f_en !== 1'b0) begin numFails++; $display("[TB] FAIL idle_hold got busy=%b f_en=%b want 0 0", busy, f_en); end
  endtask

  task automatic test_nop_halt();
    logic [5:0] expEns;
    int nPc = 0;
    apply_reset();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 6; s++) begin
        @(negedge clk);
        start = 1'b0;
        if (s == 0) icode = (k == 2) ? 4'h0 : 4'h1;
        expEns = (k == 2 && s == 5) ? 6'b000000 : (6'b100000 >> s);
        numChecks++;
        if (ens !== expEns) begin numFails++; $display("[TB] FAIL seq_ens instr%0d stage%0d got %b want %b", k, s, ens, expEns); end
        if (pc_en) nPc++;
      end
    end
    numChecks++; if (nPc != 2) begin numFails++; $display("[TB] FAIL pc_en_count got %0d want 2", nPc); end
    @(negedge clk);
    numChecks++; if (stat !== 3'd2) begin numFails++; $display("[TB] FAIL halt_stat got %0d want 2", stat); end
    numChecks++; if (busy !== 1'b0 || ens !== 6'b0) begin numFails++; $display("[TB] FAIL halt_idle got busy=%b ens=%b want 0 000000", busy, ens); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    numChecks++; if (busy !== 1'b0 || f_en !== 1'b0 || stat !== 3'd2) begin numFails++; $display("[TB] FAIL halt_start_ignored got busy=%b f_en=%b stat=%0d want 0 0 2", busy, f_en, stat); end
`ifdef SEQ_PERF_CNT_EN
    numChecks++; if (ins_cnt !== 32'd2) begin numFails++; $display("[TB] FAIL ins_cnt got %0d want 2", ins_cnt); end
    numChecks++; if (cyc_cnt !== 32'd18) begin numFails++; $display("[TB] FAIL cyc_cnt got %0d want 18", cyc_cnt); end
`endif
  endtask

  task automatic test_opq();
    apply_reset();
    start = 1'b1; cc_in = 3'b010;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      start = 1'b0;
      if (s == 0) icode = 4'h6;
      numChecks++;
      if (set_cc !== (s == 2)) begin numFails++; $display("[TB] FAIL opq_set_cc stage%0d got %b want %b", s, set_cc, (s == 2)); end
      numChecks++;
      if (cc_out !== ((s >= 3) ? 3'b010 : 3'b100)) begin numFails++; $display("[TB] FAIL opq_cc_out stage%0d got %b want %b", s, cc_out, (s >= 3) ? 3'b010 : 3'b100); end
    end
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      if (s == 0) begin icode = 4'h1; cc_in = 3'b101; cnd_in = 1'b1; end
    end
    numChecks++; if (cc_out !== 3'b010) begin numFails++; $display("[TB] FAIL nop_keeps_cc got %b want 010", cc_out); end
    numChecks++; if (cnd_q !== 1'b0) begin numFails++; $display("[TB] FAIL nop_keeps_cnd got %b want 0", cnd_q); end
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (s == 0) icode = 4'h7;
    end
    numChecks++; if (cnd_q !== 1'b1 || cc_out !== 3'b010) begin numFails++; $display("[TB] FAIL jxx_cnd got cnd=%b cc=%b want 1 010", cnd_q, cc_out); end
  endtask

  task automatic test_mem_wait();
    int nm, nr;
    apply_reset();
    start = 1'b1;
    mem_phase(4'h5, 4, 1'b0, nm, nr);
    numChecks++; if (nm != 4 || nr != 4) begin numFails++; $display("[TB] FAIL mrmov_mem_cycles got m_en=%0d req=%0d want 4 4", nm, nr); end
    numChecks++; if (w_en !== 1'b1 || mem_req !== 1'b0) begin numFails++; $display("[TB] FAIL mrmov_wb got w_en=%b req=%b want 1 0", w_en, mem_req); end
    @(negedge clk);
    numChecks++; if (pc_en !== 1'b1) begin numFails++; $display("[TB] FAIL mrmov_pc got %b want 1", pc_en); end
    mem_phase(4'h4, 1, 1'b0, nm, nr);
    numChecks++; if (nm != 1 || nr != 1) begin numFails++; $display("[TB] FAIL fast_ack_cycles got m_en=%0d req=%0d want 1 1", nm, nr); end
    numChecks++; if (w_en !== 1'b1 || stat !== 3'd1) begin numFails++; $display("[TB] FAIL fast_ack_wb got w_en=%b stat=%0d want 1 1", w_en, stat); end
    @(negedge clk);
    mem_phase(4'h8, 1, 1'b1, nm, nr);
    numChecks++; if (stat !== 3'd3 || w_en !== 1'b0 || busy !== 1'b0) begin numFails++; $display("[TB] FAIL dmem_error got stat=%0d w_en=%b busy=%b want 3 0 0", stat, w_en, busy); end
    @(negedge clk);
    numChecks++; if (ens !== 6'b0 || stat !== 3'd3) begin numFails++; $display("[TB] FAIL dmem_error_frozen got ens=%b stat=%0d want 000000 3", ens, stat); end
  endtask

  task automatic test_mem_timeout();
    int nm, nr;
    apply_reset();
    start = 1'b1;
    mem_phase(4'h4, 0, 1'b0, nm, nr);
    numChecks++; if (nm != 4 || nr != 4) begin numFails++; $display("[TB] FAIL timeout_cycles got m_en=%0d req=%0d want 4 4", nm, nr); end
    numChecks++; if (stat !== 3'd3 || mem_req !== 1'b0 || w_en !== 1'b0 || busy !== 1'b0) begin numFails++; $display("[TB] FAIL timeout_halt got stat=%0d req=%b w_en=%b busy=%b want 3 0 0 0", stat, mem_req, w_en, busy); end
  endtask

  task automatic test_fetch_errors();
    apply_reset();
    instr_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    numChecks++; if (f_en !== 1'b1) begin numFails++; $display("[TB] FAIL ins_fetch got f_en=%b want 1", f_en); end
    @(negedge clk);
    numChecks++; if (stat !== 3'd4 || d_en !== 1'b0 || busy !== 1'b0) begin numFails++; $display("[TB] FAIL ins_halt got stat=%0d d_en=%b busy=%b want 4 0 0", stat, d_en, busy); end
    apply_reset();
    imem_error = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    numChecks++; if (stat !== 3'd3 || d_en !== 1'b0) begin numFails++; $display("[TB] FAIL imem_error got stat=%0d d_en=%b want 3 0", stat, d_en); end
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    start = 1'b1; cc_in = 3'b001;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      start = 1'b0;
      if (s == 0) icode = 4'h6;
    end
    @(negedge clk); icode = 4'h5;
    repeat (3) @(negedge clk);
    numChecks++; if (mem_req !== 1'b1 || cc_out !== 3'b001) begin numFails++; $display("[TB] FAIL pre_reset got req=%b cc=%b want 1 001", mem_req, cc_out); end
    #2 rst = 1'b1;
    #1;
    numChecks++; if (mem_req !== 1'b0 || cc_out !== 3'b100 || m_en !== 1'b0 || stat !== 3'd1) begin numFails++; $display("[TB] FAIL async_reset got req=%b cc=%b m_en=%b stat=%0d want 0 100 0 1", mem_req, cc_out, m_en, stat); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nop_halt();
    test_opq();
    test_mem_wait();
    test_mem_timeout();
    test_fetch_errors();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
